// File: rtl/fir_mac_pkg.sv
// rtl/fir_mac_pkg.sv - shared state encoding and default widths for the FIR MAC scheduler
package fir_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  localparam int DEF_NUM_TAPS = 16;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_COEF_W   = 10;
  localparam int DEF_PROD_W   = DEF_DATA_W + DEF_COEF_W;

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - circular sample buffer, synchronous write, combinational indexed read
module fir_delay_line #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_mac_sched.sv
// rtl/fir_mac_sched.sv - FIR filter time-multiplexing one external multiplier, one tap per cycle
module fir_mac_sched
  import fir_mac_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int PROD_W   = DATA_W + COEF_W,
  parameter int ACC_W    = PROD_W + $clog2(NUM_TAPS)
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ACC_W-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]           coef_din,
  output logic [DATA_W-1:0]           mul_din0,
  output logic [COEF_W-1:0]           mul_din1,
  input  logic [PROD_W-1:0]           mul_dout
);

  localparam int AW = $clog2(NUM_TAPS);

  fir_state_t         state;
  logic [AW-1:0]      head;
  logic [AW-1:0]      tap;
  logic [ACC_W-1:0]   acc;
  logic [COEF_W-1:0]  coef [NUM_TAPS];

  logic               accept;
  logic [AW-1:0]      rd_idx;
  logic [DATA_W-1:0]  rd_sample;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   acc_sum;

  // Gated by reset so the source sees not-ready during the reset cycle itself.
  assign in_ready = (state == IDLE) && !ap_rst;
  assign accept   = in_valid && in_ready;
  assign rd_idx   = head - tap;
  assign prod_ext = ACC_W'($signed(mul_dout));
  assign acc_sum  = acc + prod_ext;

  fir_delay_line #(
    .DEPTH (NUM_TAPS),
    .WIDTH (DATA_W)
  ) u_delay (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .we    (accept),
    .waddr (head),
    .wdata (in_data),
    .raddr (rd_idx),
    .rdata (rd_sample)
  );

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (state == MAC) begin
      mul_din0 = rd_sample;
      mul_din1 = coef[tap];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      head      <= '0;
      tap       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NUM_TAPS; i++) coef[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A coefficient written alongside an accept is already visible at tap 0.
          if (coef_we) coef[coef_addr] <= coef_din;
          if (in_valid) begin
            acc   <= '0;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_sum;
          tap <= tap + 1'b1;
          if (tap == AW'(NUM_TAPS - 1)) begin
            out_data  <= acc_sum;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            head      <= head + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
